cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss-handling controller between the CPU's instruction/data caches and the multi-cycle main memory.
- On a cache miss it stalls the CPU and issues sequential word reads for the whole 16-byte block.
- As each word returns, it writes the word into the cache data array. After the last word it pulses the tag-array write and releases the stall.
- One instance per cache (I-cache and D-cache); the memory arbiter sits between the instances and the memory.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block (power of two).
- ADDR_W, 16, address width in bytes.
- DATA_W, 16, memory word width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- miss_detected  in  1  cache lookup missed this cycle
- miss_address  in  ADDR_W  byte address that missed
- memory_data_valid  in  1  memory_data holds a returned word this cycle
- memory_data  in  DATA_W  word returned by memory
- fsm_busy  out  1  stall request to the CPU
- mem_read_en  out  1  read request to memory this cycle
- memory_address  out  ADDR_W  address of the current read request
- write_data_array  out  1  write memory_data into the data array this cycle
- word_index  out  log2(WORDS_PER_BLOCK)  word slot written by write_data_array
- fill_data  out  DATA_W  data for the data array (equals memory_data)
- write_tag_array  out  1  write the tag/valid bit for the filled block

Behaviour:
- States: IDLE, FILL.
- Registers: base (ADDR_W), issue_cnt (log2+1 bits), recv_cnt (log2 bits).
- Reset (rst_n low, asynchronous):
  - state=IDLE, base=0, issue_cnt=0, recv_cnt=0.
  - All outputs are 0 during reset and in IDLE without a miss.
- IDLE:
  - fsm_busy = miss_detected (combinational), so the CPU stalls in the miss cycle.
  - When miss_detected: base <= miss_address with low log2(WORDS_PER_BLOCK)+1 bits cleared; counters <= 0; next state FILL.
- FILL, issue side:
  - mem_read_en = (issue_cnt < WORDS_PER_BLOCK).
  - memory_address = base + 2*issue_cnt, computed modulo 2^ADDR_W.
  - issue_cnt increments each cycle while mem_read_en is high. The first request is in the cycle after the miss; requests occupy 8 consecutive cycles.
- FILL, receive side:
  - write_data_array = memory_data_valid; word_index = recv_cnt; fill_data = memory_data.
  - recv_cnt increments on each valid.
- Completion:
  - The valid that arrives with recv_cnt == WORDS_PER_BLOCK-1 also asserts write_tag_array in that same cycle.
  - Next state is IDLE; fsm_busy drops in the following cycle.
- fsm_busy is 1 for the entire FILL state.
- Block latency = memory latency + WORDS_PER_BLOCK cycles after the miss cycle. The block does not assume any fixed latency; it only counts valids.
- Boundaries:
  - miss_detected during FILL: ignored; base is not updated.
  - memory_data_valid in IDLE: ignored; no write_data_array or write_tag_array.
  - Unaligned miss_address (e.g. 0x1237): block base 0x1230.
  - Base 0xFFF0: last request 0xFFFE; no wrap within a block.
  - A valid in the same cycle as the last issue is handled normally.
  - Reset mid-FILL: return to IDLE immediately. Valids still in flight afterwards are ignored. The tag is never written, so the block stays invalid.
  - miss_detected in the cycle following completion: a new fill starts normally (back-to-back).

Decomposition:
- Shared package cache_pkg:
  - state encoding (IDLE=1'b0, FILL=1'b1)
  - WORDS_PER_BLOCK, BLOCK_OFFSET_BITS (=4), WORD_IDX_W (=3)
- One sub-module: fill_counter, a width-parameterised up-counter with clear, increment enable and async active-low reset. It is instantiated twice, for issue_cnt and recv_cnt.

Test Plan:
- Basic fill, memory model with latency 4, miss at 0x0040:
  - Requests 0x0040, 0x0042, … 0x004E in cycles T+1 to T+8.
  - 8 write_data_array pulses with word_index 0–7, matching the returned data.
  - write_tag_array on the 8th valid only.
  - fsm_busy is high from T until the cycle after the last valid.
- Unaligned miss 0x1237:
  - Requests 0x1230–0x123E.
  - Tag written once.
- Miss_detected held high throughout FILL with a changing miss_address (0x2000 then 0x3000):
  - Only block 0x2000 is requested.
  - After the tag write there is one IDLE cycle, then a new fill of 0x3000.
- Reset asserted after the 3rd valid:
  - All outputs are 0 asynchronously.
  - Remaining model valids produce no writes and no write_tag_array.
- High-address wrap, miss 0xFFF4:
  - Requests 0xFFF0–0xFFFE.
  - No address exceeds 0xFFFE.
- Stray memory_data_valid pulses in IDLE:
  - write_data_array, write_tag_array and fsm_busy stay 0.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss fill controller.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fillStateT;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_IDX_W        = 3;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Cache-side and memory-side signals of one fill controller.
// master: the fill controller; slave: the cache/memory environment around it.
interface cache_fill_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = cache_pkg::WORD_IDX_W
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [DATA_W-1:0] memory_data;
  logic              fsm_busy;
  logic              mem_read_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [IDX_W-1:0]  word_index;
  logic [DATA_W-1:0] fill_data;
  logic              write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_read_en, memory_address, write_data_array,
           word_index, fill_data, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_read_en, memory_address, write_data_array,
           word_index, fill_data, write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear and increment enable.
module fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear wins over increment so a new fill always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the CPU, streams word reads for the
// missing block, writes returned words into the data array and finally
// writes the tag. Completion is decided by counting returned valids only,
// so any memory latency works.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input logic          clk,
  input logic          rst_n,
  cache_fill_if.master bus
);
  import cache_pkg::*;

  localparam int IDX_W    = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W    = IDX_W + 1;
  localparam int OFFSET_W = IDX_W + 1;

  fillStateT         state;
  fillStateT         stateNext;
  logic [ADDR_W-1:0] base;
  logic              baseLoad;
  logic [CNT_W-1:0]  issueCnt;
  logic [IDX_W-1:0]  recvCnt;
  logic              inFill;
  logic              issueInc;
  logic              recvInc;
  logic              recvLast;

  assign inFill   = (state == FILL);
  assign issueInc = inFill && (issueCnt < CNT_W'(WORDS_PER_BLOCK));
  assign recvInc  = inFill && bus.memory_data_valid;
  assign recvLast = (recvCnt == IDX_W'(WORDS_PER_BLOCK - 1));

  // Counters are held at zero whenever the controller is idle.
  fill_counter #(.W(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!inFill),
    .inc   (issueInc),
    .count (issueCnt)
  );

  fill_counter #(.W(IDX_W)) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!inFill),
    .inc   (recvInc),
    .count (recvCnt)
  );

  // State and block base address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      state <= stateNext;
      if (baseLoad) begin
        base <= bus.miss_address & ({ADDR_W{1'b1}} << OFFSET_W);
      end
    end
  end

  // Next-state decode and all controller outputs.
  always_comb begin
    stateNext            = state;
    baseLoad             = 1'b0;
    bus.fsm_busy         = 1'b0;
    bus.mem_read_en      = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.word_index       = '0;
    bus.fill_data        = '0;
    bus.write_tag_array  = 1'b0;
    if (state == IDLE) begin
      // Stall already in the miss cycle; forced low while reset is held.
      bus.fsm_busy = bus.miss_detected && rst_n;
      if (bus.miss_detected) begin
        baseLoad  = 1'b1;
        stateNext = FILL;
      end
    end else begin
      bus.fsm_busy         = 1'b1;
      bus.mem_read_en      = issueInc;
      bus.memory_address   = base + (ADDR_W'(issueCnt) << 1);
      bus.write_data_array = bus.memory_data_valid;
      bus.word_index       = recvCnt;
      bus.fill_data        = bus.memory_data;
      if (bus.memory_data_valid && recvLast) begin
        bus.write_tag_array = 1'b1;
        stateNext           = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Testbench for cache_fill_fsm: pipelined memory model with per-fill latency,
// expected outputs derived from the miss cycle, block base and latency.
module tb_cache_fill_fsm;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } reqT;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          memLat = 1;
  logic [15:0] salt;
  reqT         memQ[$];
  int          passCnt = 0;
  int          failCnt = 0;
  int          total = 0;

  cache_fill_if #(.ADDR_W(16), .DATA_W(16), .IDX_W(3)) bus ();

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory accepts every request it sees and answers memLat cycles later.
  always @(negedge clk) begin
    if (bus.mem_read_en === 1'b1)
      memQ.push_back(reqT'{due: cyc + memLat, addr: bus.memory_address});
  end

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and present memory responses.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    while (memQ.size() > 0 && memQ[0].due < cyc) void'(memQ.pop_front());
    if (memQ.size() > 0 && memQ[0].due == cyc) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = memWord(memQ[0].addr);
      void'(memQ.pop_front());
    end else begin
      bus.memory_data_valid = 1'b0;
      bus.memory_data       = 16'h0;
    end
  endtask

  task automatic idleCycles(input int n, input logic stray);
    for (int i = 0; i < n; i++) begin
      if (stray) begin
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = 16'($urandom);
      end
      @(negedge clk);
      chk("idleBusy", bus.fsm_busy, 1'b0);
      chk("idleRdEn", bus.mem_read_en, 1'b0);
      chk("idleWr", bus.write_data_array, 1'b0);
      chk("idleTag", bus.write_tag_array, 1'b0);
      tick();
    end
  endtask

  // One miss: cycle 0 is the miss cycle, requests in cycles 1..8, word k
  // returns in cycle k+1+lat. abortAfter>0 pulses reset after that many valids.
  task automatic doFill(input logic [15:0] missAddr, input int lat, input logic holdMiss,
                        input logic [15:0] altAddr, input int abortAfter);
    logic [15:0] base;
    int          k;
    logic        aborted;
    base    = missAddr & 16'hFFF0;
    memLat  = lat;
    aborted = 1'b0;
    bus.miss_detected = 1'b1;
    bus.miss_address  = missAddr;
    @(negedge clk);
    chk("missBusy", bus.fsm_busy, 1'b1);
    chk("missRdEn", bus.mem_read_en, 1'b0);
    chk("missWr", bus.write_data_array, 1'b0);
    for (int c = 1; c <= lat + 8; c++) begin
      tick();
      bus.miss_detected = holdMiss;
      bus.miss_address  = altAddr;
      if (abortAfter > 0 && c == lat + abortAfter + 1) begin
        rst_n = 1'b0;
        #1;
        aborted = 1'b1;
        chk("rstBusy", bus.fsm_busy, 1'b0);
        chk("rstRdEn", bus.mem_read_en, 1'b0);
        chk("rstAddr", bus.memory_address, 16'h0);
        chk("rstWr", bus.write_data_array, 1'b0);
        chk("rstIdx", bus.word_index, 3'd0);
        chk("rstData", bus.fill_data, 16'h0);
        chk("rstTag", bus.write_tag_array, 1'b0);
      end
      if (abortAfter > 0 && c == lat + abortAfter + 3) rst_n = 1'b1;
      k = c - 1 - lat;
      @(negedge clk);
      if (aborted) begin
        chk("abBusy", bus.fsm_busy, 1'b0);
        chk("abWr", bus.write_data_array, 1'b0);
        chk("abTag", bus.write_tag_array, 1'b0);
      end else begin
        chk("busy", bus.fsm_busy, 1'b1);
        chk("rdEn", bus.mem_read_en, c <= 8);
        if (c <= 8) chk("addr", bus.memory_address, base + 16'(2 * (c - 1)));
        chk("wr", bus.write_data_array, k >= 0 && k < 8);
        if (k >= 0 && k < 8) begin
          chk("wordIdx", bus.word_index, 32'(k));
          chk("fillData", bus.fill_data, memWord(base + 16'(2 * k)));
        end
        chk("tag", bus.write_tag_array, k == 7);
      end
    end
    tick();
    bus.miss_detected = holdMiss;
    bus.miss_address  = altAddr;
  endtask

  initial begin
    salt                  = 16'($urandom);
    rst_n                 = 1'b0;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'h0;
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("resetBusy", bus.fsm_busy, 1'b0);
    chk("resetRdEn", bus.mem_read_en, 1'b0);
    chk("resetAddr", bus.memory_address, 16'h0);
    chk("resetWr", bus.write_data_array, 1'b0);
    chk("resetIdx", bus.word_index, 3'd0);
    chk("resetData", bus.fill_data, 16'h0);
    chk("resetTag", bus.write_tag_array, 1'b0);
    rst_n = 1'b1;
    tick();
    idleCycles(2, 1'b0);

    doFill(16'h0040, 4, 1'b0, 16'h0, 0);
    idleCycles(1, 1'b0);
    doFill(16'h1237, 1, 1'b0, 16'h0, 0);
    idleCycles(1, 1'b0);
    doFill(16'h2000, 2, 1'b1, 16'h3000, 0);
    doFill(16'h3000, 2, 1'b0, 16'h0, 0);
    idleCycles(1, 1'b0);
    doFill(16'h5000, 4, 1'b0, 16'h0, 3);
    idleCycles(3, 1'b0);
    doFill(16'hFFF4, 5, 1'b0, 16'h0, 0);
    idleCycles(1, 1'b0);
    idleCycles(4, 1'b1);
    idleCycles(1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      doFill(16'($urandom), $urandom_range(1, 6), 1'b0, 16'h0, 0);
      idleCycles($urandom_range(0, 2), 1'b0);
    end
    idleCycles(1, 1'b0);

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

endmodule
